// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg
// Shared definitions for the ALU operation sequencer: the FSM state
// encoding and the unit-select codes carried in cmd_fun[3:2].
// No ports; imported by alu_fun_decoder and alu_op_sequencer.

package alu_seq_pkg;

    // Sequencer FSM states, in the order a command walks through them.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_WAIT  = 2'b10,
        ST_RESP  = 2'b11
    } seq_state_t;

    // Unit-select codes found in fun[3:2].
    localparam logic [1:0] UNIT_ARITH = 2'b00;
    localparam logic [1:0] UNIT_LOGIC = 2'b01;
    localparam logic [1:0] UNIT_CMP   = 2'b10;
    localparam logic [1:0] UNIT_SHIFT = 2'b11;

    // Bit positions of each unit inside the one-hot enable vector.
    localparam int EN_ARITH = 0;
    localparam int EN_LOGIC = 1;
    localparam int EN_CMP   = 2;
    localparam int EN_SHIFT = 3;

endpackage

// File: rtl/alu_fun_decoder.sv
// alu_fun_decoder
// Combinational decode of the unit-select field into a one-hot enable
// vector. The vector is all zero unless the issue strobe is high, so at
// most one unit is ever enabled and only during the issue cycle.
// Ports:
//   unit_sel  in  2  fun[3:2] unit select
//   issue     in  1  sequencer is in its issue cycle
//   enable    out 4  one-hot enable {shift, cmp, logic, arith}

module alu_fun_decoder
    import alu_seq_pkg::*;
(
    input  logic [1:0] unit_sel,
    input  logic       issue,
    output logic [3:0] enable
);

    // Default to no unit enabled; only the issue strobe opens a single unit.
    always_comb begin
        enable = 4'b0000;
        if (issue) begin
            case (unit_sel)
                UNIT_ARITH: enable[EN_ARITH] = 1'b1;
                UNIT_LOGIC: enable[EN_LOGIC] = 1'b1;
                UNIT_CMP:   enable[EN_CMP]   = 1'b1;
                UNIT_SHIFT: enable[EN_SHIFT] = 1'b1;
                default:    enable = 4'b0000;
            endcase
        end
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
// Initiator side of the ALU unit interface. Accepts one command at a time,
// presents the operands to the unit array with a single-cycle one-hot
// enable, waits for the ORed unit flag (or a timeout) and returns the
// captured result over a valid/ready response handshake.
// Ports:
//   clk, rst                       clock (rising edge), async active-high reset
//   cmd_valid/cmd_ready            command handshake
//   cmd_a, cmd_b, cmd_fun          operands and function ([3:2] unit, [1:0] sub)
//   unit_a, unit_b, unit_fun       operands and sub-function to the units
//   arith/logic/cmp/shift_enable   one-hot unit enables, high only in ISSUE
//   res_in, flag_in                ORed unit result and valid flag
//   rsp_valid/rsp_ready            response handshake
//   rsp_data, rsp_error            captured result, 1 = timed out

module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DATA_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [DATA_WIDTH-1:0] cmd_a,
    input  logic [DATA_WIDTH-1:0] cmd_b,
    input  logic [3:0]            cmd_fun,
    output logic [DATA_WIDTH-1:0] unit_a,
    output logic [DATA_WIDTH-1:0] unit_b,
    output logic [1:0]            unit_fun,
    output logic                  arith_enable,
    output logic                  logic_enable,
    output logic                  cmp_enable,
    output logic                  shift_enable,
    input  logic [DATA_WIDTH-1:0] res_in,
    input  logic                  flag_in,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_error
);

    // Counter must be able to hold TIMEOUT_CYCLES-1; the +1 keeps a
    // TIMEOUT_CYCLES of 1 at a legal one-bit width.
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    seq_state_t            state;
    seq_state_t            state_next;
    logic [DATA_WIDTH-1:0] a_reg;
    logic [DATA_WIDTH-1:0] b_reg;
    logic [3:0]            fun_reg;
    logic [CNT_W-1:0]      count;
    logic [3:0]            enable;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. ISSUE always lasts exactly one cycle; WAIT leaves on
    // the flag or when the counter has used up its budget.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (cmd_valid) state_next = ST_ISSUE;
            ST_ISSUE: state_next = ST_WAIT;
            ST_WAIT:  if (flag_in || (count == CNT_LAST)) state_next = ST_RESP;
            ST_RESP:  if (rsp_ready) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Datapath registers: command capture, timeout counter and response.
    // A flag in the final WAIT cycle wins over the timeout. flag_in is only
    // looked at in WAIT, so stray flags elsewhere leave everything untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg     <= '0;
            b_reg     <= '0;
            fun_reg   <= '0;
            count     <= '0;
            rsp_data  <= '0;
            rsp_error <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        a_reg   <= cmd_a;
                        b_reg   <= cmd_b;
                        fun_reg <= cmd_fun;
                    end
                end
                ST_ISSUE: begin
                    count <= '0;
                end
                ST_WAIT: begin
                    if (flag_in) begin
                        rsp_data  <= res_in;
                        rsp_error <= 1'b0;
                    end else if (count == CNT_LAST) begin
                        rsp_data  <= '0;
                        rsp_error <= 1'b1;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Unit enables are only opened during the issue cycle.
    alu_fun_decoder u_decoder (
        .unit_sel (fun_reg[3:2]),
        .issue    (state == ST_ISSUE),
        .enable   (enable)
    );

    assign arith_enable = enable[EN_ARITH];
    assign logic_enable = enable[EN_LOGIC];
    assign cmp_enable   = enable[EN_CMP];
    assign shift_enable = enable[EN_SHIFT];

    // Operand outputs come straight from the capture registers, so they are
    // valid in ISSUE and hold unchanged through WAIT.
    assign unit_a    = a_reg;
    assign unit_b    = b_reg;
    assign unit_fun  = fun_reg[1:0];

    assign cmd_ready = (state == ST_IDLE);
    assign rsp_valid = (state == ST_RESP);

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer
// Self-checking bench for alu_op_sequencer. A small unit-array responder
// answers enabled operations one cycle later; the driver pushes the
// hand-computed expected response into a queue and a monitor pops and
// compares whenever a response handshake occurs.

module tb_alu_op_sequencer;

    localparam int DW = 16;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [DW-1:0] cmd_a;
    logic [DW-1:0] cmd_b;
    logic [3:0]    cmd_fun;
    logic [DW-1:0] unit_a;
    logic [DW-1:0] unit_b;
    logic [1:0]    unit_fun;
    logic          arith_enable;
    logic          logic_enable;
    logic          cmp_enable;
    logic          shift_enable;
    logic [DW-1:0] res_in;
    logic          flag_in;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;
    logic          rsp_error;

    logic          unit_flag;
    logic [DW-1:0] unit_res;
    logic          stray_flag;
    logic [DW-1:0] stray_res;
    logic          suppress;

    typedef struct {
        logic [DW-1:0] data;
        logic          err;
        int            lat;
        logic [3:0]    en;
        logic [1:0]    fun;
    } exp_t;

    exp_t exp_q[$];
    int   acc_q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    alu_op_sequencer #(.DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_a        (cmd_a),
        .cmd_b        (cmd_b),
        .cmd_fun      (cmd_fun),
        .unit_a       (unit_a),
        .unit_b       (unit_b),
        .unit_fun     (unit_fun),
        .arith_enable (arith_enable),
        .logic_enable (logic_enable),
        .cmp_enable   (cmp_enable),
        .shift_enable (shift_enable),
        .res_in       (res_in),
        .flag_in      (flag_in),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .rsp_error    (rsp_error)
    );

    // Behaviour of the unit array as seen through the OR tree.
    function automatic logic [DW-1:0] unitResult(input logic [3:0] en, input logic [1:0] f,
                                                 input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [DW-1:0] r;
        r = '0;
        if (en[0]) r = (f == 2'b01) ? a - b : a + b;
        if (en[1]) begin
            case (f)
                2'b00:   r = a & b;
                2'b01:   r = a | b;
                2'b10:   r = a ^ b;
                default: r = ~(a | b);
            endcase
        end
        if (en[2]) r = (f == 2'b01) ? DW'(a == b) : DW'(a < b);
        if (en[3]) r = (f == 2'b01) ? a >> b[3:0] : a << b[3:0];
        return r;
    endfunction

    // Unit array responder: registers result and flag one cycle after enable.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            unit_flag <= 1'b0;
            unit_res  <= '0;
        end else begin
            unit_flag <= 1'b0;
            unit_res  <= '0;
            if ((arith_enable | logic_enable | cmp_enable | shift_enable) && !suppress) begin
                unit_flag <= 1'b1;
                unit_res  <= unitResult({shift_enable, cmp_enable, logic_enable, arith_enable},
                                        unit_fun, unit_a, unit_b);
            end
        end
    end

    assign flag_in = unit_flag | stray_flag;
    assign res_in  = unit_res | stray_res;

    function automatic exp_t mkExp(input logic [DW-1:0] d, input logic e, input int l,
                                   input logic [3:0] en, input logic [1:0] f);
        exp_t x;
        x.data = d;
        x.err  = e;
        x.lat  = l;
        x.en   = en;
        x.fun  = f;
        return x;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Issue one command and push its expected response; returns once accepted.
    task automatic applyStimulus(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [3:0] f,
                                 input logic [DW-1:0] d, input logic e, input int l, input logic [3:0] en);
        int guard;
        guard = 0;
        while (!cmd_ready && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        if (!cmd_ready) checkOutput("cmd_ready_wait", {31'b0, cmd_ready}, 1);
        cmd_a     = a;
        cmd_b     = b;
        cmd_fun   = f;
        cmd_valid = 1'b1;
        exp_q.push_back(mkExp(d, e, l, en, f[1:0]));
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic waitDone();
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 60) begin
            @(negedge clk);
            guard++;
        end
        if (exp_q.size() != 0) begin
            checkOutput("response_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    // Monitor: tracks accepts, enable pulses and response handshakes.
    initial begin
        logic       prev_valid;
        int         en_count;
        logic [3:0] seen_en;
        logic [1:0] seen_fun;
        logic [3:0] en;
        int         acc;
        exp_t       x;
        prev_valid = 1'b0;
        en_count   = 0;
        seen_en    = '0;
        seen_fun   = '0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                prev_valid = 1'b0;
                en_count   = 0;
                continue;
            end
            en = {shift_enable, cmp_enable, logic_enable, arith_enable};
            if (en != 4'b0000) begin
                en_count++;
                seen_en  = en;
                seen_fun = unit_fun;
            end
            if (cmd_valid && cmd_ready) begin
                acc_q.push_back(cyc + 1);
                en_count = 0;
                seen_en  = '0;
            end
            if (rsp_valid && !prev_valid) begin
                if (acc_q.size() == 0 || exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("[TB] FAIL unexpected_rsp: got rsp_valid=1 data=%0h, expected no response", rsp_data);
                end else begin
                    acc = acc_q.pop_front();
                    checkOutput("latency", cyc - acc, exp_q[0].lat);
                end
            end
            if (rsp_valid && rsp_ready && exp_q.size() != 0) begin
                x = exp_q.pop_front();
                checkOutput("rsp_data", rsp_data, x.data);
                checkOutput("rsp_error", {31'b0, rsp_error}, {31'b0, x.err});
                checkOutput("enable_cycles", en_count, 1);
                checkOutput("enable_vector", seen_en, x.en);
                checkOutput("unit_fun", seen_fun, x.fun);
            end
            prev_valid = rsp_valid;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int acc_t[3];
        logic [DW-1:0] b2b_a[3];
        logic [DW-1:0] b2b_b[3];
        logic [3:0]    b2b_f[3];
        logic [DW-1:0] b2b_d[3];
        logic [3:0]    b2b_en[3];
        int guard;

        b2b_a  = '{16'h0010, 16'h0005, 16'h0001};
        b2b_b  = '{16'h0001, 16'h0009, 16'h0004};
        b2b_f  = '{4'b0001, 4'b1000, 4'b1100};
        b2b_d  = '{16'h000F, 16'h0001, 16'h0010};
        b2b_en = '{4'b0001, 4'b0100, 4'b1000};

        rst        = 1'b1;
        cmd_valid  = 1'b0;
        cmd_a      = '0;
        cmd_b      = '0;
        cmd_fun    = '0;
        rsp_ready  = 1'b1;
        suppress   = 1'b0;
        stray_flag = 1'b0;
        stray_res  = '0;

        // Reset state.
        repeat (2) @(negedge clk);
        checkOutput("reset_cmd_ready", {31'b0, cmd_ready}, 1);
        checkOutput("reset_rsp_valid", {31'b0, rsp_valid}, 0);
        checkOutput("reset_rsp_data", rsp_data, 0);
        checkOutput("reset_enables", {shift_enable, cmp_enable, logic_enable, arith_enable}, 0);
        checkOutput("reset_unit_a", unit_a, 0);
        rst = 1'b0;
        @(negedge clk);

        // Logic AND.
        applyStimulus(16'hF0F0, 16'hFF00, 4'b0100, 16'hF000, 1'b0, 2, 4'b0010);
        waitDone();

        // Backpressure with logic NOR.
        rsp_ready = 1'b0;
        applyStimulus(16'h00FF, 16'h0F00, 4'b0111, 16'hF000, 1'b0, 2, 4'b0010);
        guard = 0;
        while (!rsp_valid && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp_rsp_valid", {31'b0, rsp_valid}, 1);
            checkOutput("bp_rsp_data", rsp_data, 16'hF000);
            checkOutput("bp_cmd_ready", {31'b0, cmd_ready}, 0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("bp_idle_after_ready", {31'b0, cmd_ready}, 1);
        waitDone();

        // Timeout: no flag ever returned.
        suppress = 1'b1;
        applyStimulus(16'h0001, 16'h0004, 4'b1100, 16'h0000, 1'b1, TO + 1, 4'b1000);
        waitDone();
        suppress = 1'b0;

        // Reset while waiting for the flag.
        suppress = 1'b1;
        applyStimulus(16'h1111, 16'h2222, 4'b0000, 16'h3333, 1'b0, 2, 4'b0001);
        @(negedge clk);
        rst = 1'b1;
        #1;
        exp_q.delete();
        acc_q.delete();
        checkOutput("rstwait_rsp_valid", {31'b0, rsp_valid}, 0);
        checkOutput("rstwait_rsp_data", rsp_data, 0);
        checkOutput("rstwait_rsp_error", {31'b0, rsp_error}, 0);
        checkOutput("rstwait_unit_a", unit_a, 0);
        checkOutput("rstwait_unit_b", unit_b, 0);
        checkOutput("rstwait_enables", {shift_enable, cmp_enable, logic_enable, arith_enable}, 0);
        @(negedge clk);
        rst      = 1'b0;
        suppress = 1'b0;
        @(negedge clk);
        checkOutput("rstwait_cmd_ready", {31'b0, cmd_ready}, 1);
        applyStimulus(16'h0003, 16'h0004, 4'b0000, 16'h0007, 1'b0, 2, 4'b0001);
        waitDone();

        // Back-to-back commands with cmd_valid held high.
        for (int i = 0; i < 3; i++) begin
            guard = 0;
            do begin
                @(negedge clk);
                guard++;
            end while (!cmd_ready && guard < 20);
            if (!cmd_ready) checkOutput("b2b_ready_wait", {31'b0, cmd_ready}, 1);
            cmd_a     = b2b_a[i];
            cmd_b     = b2b_b[i];
            cmd_fun   = b2b_f[i];
            cmd_valid = 1'b1;
            exp_q.push_back(mkExp(b2b_d[i], 1'b0, 2, b2b_en[i], b2b_f[i][1:0]));
            acc_t[i] = cyc + 1;
            @(posedge clk);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        checkOutput("b2b_spacing_01", acc_t[1] - acc_t[0], 4);
        checkOutput("b2b_spacing_12", acc_t[2] - acc_t[1], 4);
        waitDone();

        // Stray flag in IDLE must be ignored.
        stray_flag = 1'b1;
        stray_res  = 16'hABCD;
        @(negedge clk);
        stray_flag = 1'b0;
        stray_res  = '0;
        checkOutput("stray_cmd_ready", {31'b0, cmd_ready}, 1);
        checkOutput("stray_rsp_valid", {31'b0, rsp_valid}, 0);
        applyStimulus(16'h1200, 16'h0034, 4'b0101, 16'h1234, 1'b0, 2, 4'b0010);
        waitDone();

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Initiator side of the ALU unit interface. Accepts operation commands over a valid/ready handshake and decodes the 4-bit function into a one-hot unit enable plus a 2-bit sub-function.
- Drives operands to the arithmetic, logic, compare and shift units for one cycle. Waits for the registered flag and returns the result over a valid/ready response handshake.
- Sits between the ALU top-level command source and the unit array. At top level, unit outputs and flags are ORed, since disabled units register zero.

Parameters:
- DATA_WIDTH, 16, operand/result width.
- TIMEOUT_CYCLES, 4, WAIT cycles allowed for flag_in before an error response; minimum 1.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer accepts command
- cmd_a  in  DATA_WIDTH  operand A
- cmd_b  in  DATA_WIDTH  operand B
- cmd_fun  in  4  [3:2] unit select, [1:0] sub-function
- unit_a  out  DATA_WIDTH  operand A to units
- unit_b  out  DATA_WIDTH  operand B to units
- unit_fun  out  2  sub-function to units
- arith_enable  out  1  arithmetic unit enable
- logic_enable  out  1  logic unit enable
- cmp_enable  out  1  compare unit enable
- shift_enable  out  1  shift unit enable
- res_in  in  DATA_WIDTH  ORed unit result
- flag_in  in  1  ORed unit valid flag
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_data  out  DATA_WIDTH  captured result
- rsp_error  out  1  1 = timeout, no flag received

Behaviour:
- Reset (rst high, async): state IDLE, all registered outputs 0, timeout counter 0, in-flight command dropped, no response issued. After reset, cmd_ready=1.
- FSM states: IDLE, ISSUE, WAIT, RESP.
  - IDLE: cmd_ready=1. On cmd_valid&&cmd_ready, capture cmd_a/cmd_b/cmd_fun into registers, go to ISSUE.
  - ISSUE (exactly one cycle):
    - Drive unit_a/unit_b/unit_fun from the captured registers.
    - Assert exactly one enable, decoded from the captured fun[3:2]: 00 arith, 01 logic, 10 cmp, 11 shift.
    - Clear the timeout counter, go to WAIT.
  - WAIT:
    - All enables 0; unit_a/unit_b/unit_fun hold their values.
    - flag_in=1: capture res_in into rsp_data, rsp_error=0, go to RESP.
    - Otherwise the counter increments. At count TIMEOUT_CYCLES-1 with no flag: rsp_data=0, rsp_error=1, go to RESP.
  - RESP: rsp_valid=1, with rsp_data/rsp_error stable until rsp_ready. On rsp_valid&&rsp_ready, clear rsp_valid and go to IDLE.
- Enables are 0 in every state except ISSUE; never more than one high.
- cmd_ready=0 in ISSUE/WAIT/RESP. No command queuing.
- flag_in outside WAIT is ignored (no state or output change).
- Latency:
  - Accept at edge E0; enable high during E0..E1; flag sampled at E2.
  - rsp_valid is high the cycle after E2, i.e. 2 edges after accept.
  - With rsp_ready held high, throughput is one command per 4 cycles.
- Width: res_in passes through unmodified, with no extension or truncation.

Decomposition:
- Shared package alu_seq_pkg: FSM state encoding, unit-select codes (UNIT_ARITH=2'b00, UNIT_LOGIC=2'b01, UNIT_CMP=2'b10, UNIT_SHIFT=2'b11).
- One sub-module: alu_fun_decoder, combinational, fun[3:2] plus issue strobe to a one-hot 4-bit enable vector.

Test Plan:
- Logic AND: cmd a=16'hF0F0, b=16'hFF00, fun=4'b0100, rsp_ready=1 -> logic_enable high exactly 1 cycle with unit_fun=2'b00, other enables 0; rsp_valid 2 edges after accept; rsp_data=16'hF000; rsp_error=0.
- Backpressure: logic NOR a=16'h00FF, b=16'h0F00 (fun=4'b0111), rsp_ready low 5 cycles -> rsp_valid and rsp_data=16'hF000 stable, cmd_ready=0 throughout; IDLE one cycle after rsp_ready rises.
- Timeout: TIMEOUT_CYCLES=4, fun=4'b1100, flag_in tied 0 -> rsp_valid after 4 WAIT cycles, rsp_data=16'h0000, rsp_error=1.
- Reset mid-WAIT: assert rst during WAIT -> all outputs 0 immediately (async), no response; next command after release completes normally.
- Back-to-back: cmd_valid held high, 3 commands, rsp_ready=1 -> accepts exactly 4 cycles apart; responses in order with correct data.
- Stray flag: pulse flag_in in IDLE with res_in=16'hABCD, then issue a logic OR command -> rsp_data reflects the commanded result, never 16'hABCD.
